// File: rtl/text_window_generator_if.sv
// text_window_generator_if: pixel, buffer-write, cursor and Font_rom signals of the text window.
// master drives the pixel stream, writes and font_word; slave is the generator itself.
interface text_window_generator_if #(parameter int AW = 4);
   logic          video_on;
   logic [9:0]    pixel_x;
   logic [9:0]    pixel_y;
   logic          frame_tick;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [6:0]    wr_char;
   logic [6:0]    cur_col;
   logic [4:0]    cur_row;
   logic [7:0]    switch;
   logic [10:0]   font_addr;
   logic [7:0]    font_word;
   logic [2:0]    rgb_text;
   modport master (
      output video_on, pixel_x, pixel_y, frame_tick, wr_en, wr_addr, wr_char,
             cur_col, cur_row, switch, font_word,
      input  font_addr, rgb_text
   );
   modport slave (
      input  video_on, pixel_x, pixel_y, frame_tick, wr_en, wr_addr, wr_char,
             cur_col, cur_row, switch, font_word,
      output font_addr, rgb_text
   );
endinterface

// File: rtl/text_window_generator.sv
// text_window_generator: N_COLS x N_ROWS text window of 8x16 glyphs from a writable buffer.
// Define CURSOR_BLINK_EN to add a frame-counted blinking cursor that swaps fg/bg in its cell.
module text_window_generator #(
   parameter int N_COLS       = 8,
   parameter int N_ROWS       = 2,
   parameter int X0           = 0,
   parameter int Y0           = 0,
   parameter int BLINK_FRAMES = 30,
   parameter int AW           = (N_COLS * N_ROWS > 1) ? $clog2(N_COLS * N_ROWS) : 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   text_window_generator_if.slave bus
);
   localparam int N_CELLS = N_COLS * N_ROWS;
   logic [9:0]    dx, dy;
   logic          in_win, cur_hit, phase;
   logic [AW-1:0] rd_addr;
   logic [6:0]    mem [N_CELLS];
   logic [6:0]    s0_char, s0_col;
   logic [4:0]    s0_row;
   logic [3:0]    s0_grow;
   logic [2:0]    s0_bit, s1_bit, fg, bg;
   logic          s0_win, s0_von, s1_win, s1_von, s1_swap;
   always_comb begin
      dx      = bus.pixel_x - 10'(X0);
      dy      = bus.pixel_y - 10'(Y0);
      in_win  = int'(bus.pixel_x) >= X0 && int'(bus.pixel_x) < X0 + 8 * N_COLS &&
                int'(bus.pixel_y) >= Y0 && int'(bus.pixel_y) < Y0 + 16 * N_ROWS;
      rd_addr = in_win ? AW'(int'(dy[9:4]) * N_COLS + int'(dx[9:3])) : '0;
      cur_hit = phase && s0_win && s0_col == bus.cur_col && s0_row == bus.cur_row;
      fg      = s1_swap ? bus.switch[5:3] : bus.switch[2:0];
      bg      = s1_swap ? bus.switch[2:0] : bus.switch[5:3];
   end
   // Writes land on the edge, so an S0 read of the same cell in that cycle sees the old code.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         for (int i = 0; i < N_CELLS; i++) mem[i] <= '0;
      else if (bus.wr_en && int'(bus.wr_addr) < N_CELLS)
         mem[AW'(bus.wr_addr)] <= bus.wr_char;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s0_char      <= '0;
         s0_col       <= '0;
         s0_row       <= '0;
         s0_grow      <= '0;
         s0_bit       <= '0;
         s0_win       <= 1'b0;
         s0_von       <= 1'b0;
         s1_bit       <= '0;
         s1_win       <= 1'b0;
         s1_von       <= 1'b0;
         s1_swap      <= 1'b0;
         bus.font_addr <= '0;
         bus.rgb_text  <= '0;
      end else begin
         s0_char      <= mem[rd_addr];
         s0_col       <= dx[9:3];
         s0_row       <= dy[8:4];
         s0_grow      <= dy[3:0];
         s0_bit       <= dx[2:0];
         s0_win       <= in_win;
         s0_von       <= bus.video_on;
         if (s0_win) bus.font_addr <= {s0_char, s0_grow};
         s1_bit       <= s0_bit;
         s1_win       <= s0_win;
         s1_von       <= s0_von;
         s1_swap      <= cur_hit;
         bus.rgb_text <= !s1_von ? 3'b000 : (s1_win && bus.font_word[3'd7 - s1_bit]) ? fg : bg;
      end
`ifdef CURSOR_BLINK_EN
   localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [CW-1:0] blink_cnt;
   logic          blink_wrap;
   assign blink_wrap = blink_cnt == CW'(BLINK_FRAMES - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (bus.frame_tick) begin
         blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
         phase     <= blink_wrap ? ~phase : phase;
      end
`else
   assign phase = 1'b0;
`endif
endmodule
